// File: rtl/cam_ctrl.sv
// cam_ctrl: sequencing and arbitration controller for a 16-entry CAM.
// Two requesters share the CAM under a round-robin grant. Each request is a
// lookup, or a lookup followed by a write into the next free slot (insert).
// The controller also owns the CAM reset line used for table flushes.
// Optional feature: define CAM_CTRL_STATS_EN to enable the hit, miss and
// reject counters. When it is undefined the stat ports are tied to 0.
module cam_ctrl #(
    parameter int NB_ENTRIES = 16,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_insert,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_insert,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              flush,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic              rsp_hit,
    output logic [4:0]        rsp_idx,
    output logic              rsp_err,
    output logic              full,
    output logic              cam_enable,
    output logic              cam_write,
    output logic [4:0]        cam_addr,
    output logic [DATA_W-1:0] cam_data,
    output logic              cam_rst_n,
    input  logic [4:0]        cam_out,
    output logic [15:0]       stat_hits,
    output logic [15:0]       stat_misses,
    output logic [15:0]       stat_rejects
);

    // The allocation pointer stops at this value; slot 0 is never handed out.
    localparam logic [4:0] LAST_PTR = 5'(NB_ENTRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_CHECK,
        S_WRITE,
        S_RESP,
        S_FLUSH
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic                last_gnt;
    logic                flush_pending;
    logic [4:0]          alloc_ptr;

    logic                lat_id;
    logic                lat_insert;
    logic [DATA_W-1:0]   lat_key;

    logic                flush_req;
    logic                gnt0;
    logic                gnt1;
    logic                hs;
    logic                hs_id;
    logic                hs_insert;
    logic [DATA_W-1:0]   hs_key;

    logic                rsp_id_nx;
    logic                rsp_hit_nx;
    logic [4:0]          rsp_idx_nx;
    logic                rsp_err_nx;

    // A flush, either arriving now or parked earlier, blocks new grants.
    assign flush_req = flush | flush_pending;

    // Round robin: on a tie the requester that was not granted last wins.
    assign gnt0 = req0_valid & (~req1_valid | last_gnt);
    assign gnt1 = req1_valid & (~req0_valid | ~last_gnt);

    assign req0_ready = (state == S_IDLE) & gnt0 & ~flush_req;
    assign req1_ready = (state == S_IDLE) & gnt1 & ~flush_req;

    assign hs        = req0_ready | req1_ready;
    assign hs_id     = req1_ready;
    assign hs_insert = req1_ready ? req1_insert : req0_insert;
    assign hs_key    = req1_ready ? req1_data : req0_data;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and the response fields to load on entry to RESP.
    always_comb begin
        state_nx   = state;
        rsp_id_nx  = lat_id;
        rsp_hit_nx = 1'b0;
        rsp_idx_nx = '0;
        rsp_err_nx = 1'b0;
        case (state)
            S_IDLE: begin
                if (flush_req) begin
                    state_nx = S_FLUSH;
                end else if (hs) begin
                    rsp_id_nx = hs_id;
                    if (hs_key == '0) begin
                        // Key 0 marks unused CAM slots, so it can never be stored.
                        state_nx   = S_RESP;
                        rsp_err_nx = 1'b1;
                    end else begin
                        state_nx = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
                state_nx = S_CHECK;
            end
            S_CHECK: begin
                if (cam_out != '0) begin
                    state_nx   = S_RESP;
                    rsp_hit_nx = 1'b1;
                    rsp_idx_nx = cam_out;
                end else if (!lat_insert) begin
                    state_nx = S_RESP;
                end else if (full) begin
                    state_nx   = S_RESP;
                    rsp_err_nx = 1'b1;
                end else begin
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                state_nx   = S_RESP;
                rsp_idx_nx = alloc_ptr;
            end
            S_RESP: begin
                state_nx = S_IDLE;
            end
            S_FLUSH: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Arbitration pointer, flush bookkeeping and slot allocation.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt      <= 1'b1;
            flush_pending <= 1'b0;
            alloc_ptr     <= 5'd1;
            full          <= 1'b0;
        end else begin
            if (hs) begin
                last_gnt <= hs_id;
            end
            if (state == S_FLUSH) begin
                alloc_ptr     <= 5'd1;
                full          <= 1'b0;
                flush_pending <= flush;
            end else begin
                // In IDLE a flush is taken straight away, elsewhere it waits.
                if (flush && (state != S_IDLE)) begin
                    flush_pending <= 1'b1;
                end
                if (state == S_WRITE) begin
                    alloc_ptr <= alloc_ptr + 5'd1;
                    full      <= (alloc_ptr + 5'd1) == LAST_PTR;
                end
            end
        end
    end

    // Request capture at the handshake; pure data, so no reset.
    always_ff @(posedge clk) begin
        if (hs) begin
            lat_id     <= hs_id;
            lat_insert <= hs_insert;
            lat_key    <= hs_key;
        end
    end

    // Registered response bus and CAM strobes, decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_hit    <= 1'b0;
            rsp_idx    <= '0;
            rsp_err    <= 1'b0;
            cam_enable <= 1'b0;
            cam_write  <= 1'b0;
            cam_addr   <= '0;
            cam_data   <= '0;
            cam_rst_n  <= 1'b0;
        end else begin
            rsp_valid  <= (state_nx == S_RESP);
            rsp_id     <= (state_nx == S_RESP) ? rsp_id_nx : 1'b0;
            rsp_hit    <= (state_nx == S_RESP) ? rsp_hit_nx : 1'b0;
            rsp_idx    <= (state_nx == S_RESP) ? rsp_idx_nx : 5'd0;
            rsp_err    <= (state_nx == S_RESP) ? rsp_err_nx : 1'b0;
            cam_enable <= (state_nx == S_LOOKUP);
            cam_write  <= (state_nx == S_WRITE);
            cam_rst_n  <= (state_nx != S_FLUSH);
            if (state_nx == S_LOOKUP) begin
                cam_data <= hs_key;
            end else if (state_nx == S_WRITE) begin
                cam_data <= lat_key;
            end
            if (state_nx == S_WRITE) begin
                cam_addr <= alloc_ptr;
            end
        end
    end

`ifdef CAM_CTRL_STATS_EN
    // Saturating increment so a long run never wraps back to a small count.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // One counter steps per response strobe; a flush or reset clears all three.
    always_ff @(posedge clk) begin
        if (rst || (state == S_FLUSH)) begin
            stat_hits    <= '0;
            stat_misses  <= '0;
            stat_rejects <= '0;
        end else if (rsp_valid) begin
            if (rsp_hit) begin
                stat_hits <= sat_inc(stat_hits);
            end else if (rsp_err) begin
                stat_rejects <= sat_inc(stat_rejects);
            end else begin
                stat_misses <= sat_inc(stat_misses);
            end
        end
    end
`else
    assign stat_hits    = '0;
    assign stat_misses  = '0;
    assign stat_rejects = '0;
`endif

endmodule

// File: tb/tb_cam_ctrl.sv
// tb_cam_ctrl: bench for cam_ctrl with a behavioural CAM attached and a
// transaction-level reference model that predicts every output cycle by cycle.
module tb_cam_ctrl;

    localparam int NB = 16;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_insert, req0_ready;
    logic [7:0]  req0_data;
    logic        req1_valid, req1_insert, req1_ready;
    logic [7:0]  req1_data;
    logic        flush;
    logic        rsp_valid, rsp_id, rsp_hit, rsp_err, full;
    logic [4:0]  rsp_idx;
    logic        cam_enable, cam_write, cam_rst_n;
    logic [4:0]  cam_addr;
    logic [7:0]  cam_data;
    logic [4:0]  cam_out;
    logic [15:0] stat_hits, stat_misses, stat_rejects;

    int checks = 0;
    int errors = 0;

    cam_ctrl #(.NB_ENTRIES(NB), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_insert(req0_insert), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_insert(req1_insert), .req1_data(req1_data), .req1_ready(req1_ready),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_hit(rsp_hit), .rsp_idx(rsp_idx), .rsp_err(rsp_err),
        .full(full),
        .cam_enable(cam_enable), .cam_write(cam_write), .cam_addr(cam_addr), .cam_data(cam_data),
        .cam_rst_n(cam_rst_n), .cam_out(cam_out),
        .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_rejects(stat_rejects)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural CAM: registered match index, writes only while the held match is 0.
    logic [7:0] cam_mem [NB];
    always @(posedge clk or negedge cam_rst_n) begin
        if (!cam_rst_n) begin
            for (int i = 0; i < NB; i++) cam_mem[i] <= 8'h00;
            cam_out <= 5'd0;
        end else begin
            if (cam_write && cam_out == 5'd0) cam_mem[cam_addr[3:0]] <= cam_data;
            if (cam_enable) begin
                logic [4:0] m;
                m = 5'd0;
                for (int i = NB - 1; i >= 1; i--) if (cam_mem[i] == cam_data) m = 5'(i);
                cam_out <= m;
            end
        end
    end

    // Reference model state: stored keys, next free slot, scheduled events.
    logic [7:0] tbl [NB];
    int  cyc = 0;
    bit  prev_rst = 1'b1;
    int  free_cyc, rsp_cyc, en_cyc, wr_cyc, rstlow_cyc;
    bit  fpend;
    int  last_g;
    int  alloc;
    int  n_hit, n_miss, n_rej;
    logic       e_id, e_hit, e_err;
    logic [4:0] e_idx, e_wraddr;
    logic [7:0] e_key;

    // Compare outputs for this cycle, then advance the model with this cycle's inputs.
    always @(negedge clk) begin : model_p
        logic e_r0, e_r1, ins;
        logic [7:0] key;
        int g, found;
        cyc++;
        if (prev_rst) begin
            chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
            chk("rst_cam_enable", 32'(cam_enable), 32'(0));
            chk("rst_cam_write", 32'(cam_write), 32'(0));
            chk("rst_cam_rst_n", 32'(cam_rst_n), 32'(0));
            chk("rst_full", 32'(full), 32'(0));
            chk("rst_cam_addr", 32'(cam_addr), 32'(0));
            chk("rst_cam_data", 32'(cam_data), 32'(0));
        end else begin
            chk("rsp_valid", 32'(rsp_valid), 32'(cyc == rsp_cyc));
            if (cyc == rsp_cyc) begin
                chk("rsp_id", 32'(rsp_id), 32'(e_id));
                chk("rsp_hit", 32'(rsp_hit), 32'(e_hit));
                chk("rsp_idx", 32'(rsp_idx), 32'(e_idx));
                chk("rsp_err", 32'(rsp_err), 32'(e_err));
            end
            chk("cam_enable", 32'(cam_enable), 32'(cyc == en_cyc));
            if (cyc == en_cyc) chk("cam_data_lookup", 32'(cam_data), 32'(e_key));
            chk("cam_write", 32'(cam_write), 32'(cyc == wr_cyc));
            if (cyc == wr_cyc) begin
                chk("cam_addr", 32'(cam_addr), 32'(e_wraddr));
                chk("cam_data_write", 32'(cam_data), 32'(e_key));
            end
            chk("cam_rst_n", 32'(cam_rst_n), 32'(cyc != rstlow_cyc));
            if (cyc >= free_cyc) begin
                chk("full", 32'(full), 32'(alloc == NB));
`ifdef CAM_CTRL_STATS_EN
                chk("stat_hits", 32'(stat_hits), 32'(n_hit));
                chk("stat_misses", 32'(stat_misses), 32'(n_miss));
                chk("stat_rejects", 32'(stat_rejects), 32'(n_rej));
`else
                chk("stat_tied", 32'({stat_hits, stat_misses | stat_rejects}), 32'(0));
`endif
            end
        end

        if (rst) begin
            prev_rst = 1'b1;
            fpend = 1'b0; last_g = 1; alloc = 1; free_cyc = 0;
            rsp_cyc = -1; en_cyc = -1; wr_cyc = -1; rstlow_cyc = -1;
            n_hit = 0; n_miss = 0; n_rej = 0;
            for (int i = 0; i < NB; i++) tbl[i] = 8'h00;
        end else begin
            prev_rst = 1'b0;
            e_r0 = 1'b0; e_r1 = 1'b0;
            if (cyc >= free_cyc) begin
                if (flush || fpend) begin
                    fpend = 1'b0; rstlow_cyc = cyc + 1; free_cyc = cyc + 2;
                    alloc = 1; n_hit = 0; n_miss = 0; n_rej = 0;
                    for (int i = 0; i < NB; i++) tbl[i] = 8'h00;
                end else if (req0_valid || req1_valid) begin
                    if (req0_valid && req1_valid) g = (last_g == 1) ? 0 : 1;
                    else g = req1_valid ? 1 : 0;
                    last_g = g;
                    if (g == 1) begin e_r1 = 1'b1; key = req1_data; ins = req1_insert; end
                    else begin e_r0 = 1'b1; key = req0_data; ins = req0_insert; end
                    e_id = (g == 1); e_hit = 1'b0; e_idx = 5'd0; e_err = 1'b0;
                    if (key == 8'h00) begin
                        e_err = 1'b1; rsp_cyc = cyc + 1; n_rej++;
                    end else begin
                        en_cyc = cyc + 1; e_key = key;
                        found = 0;
                        for (int i = 1; i < alloc; i++) if (tbl[i] == key) found = i;
                        rsp_cyc = cyc + 3;
                        if (found != 0) begin
                            e_hit = 1'b1; e_idx = 5'(found); n_hit++;
                        end else if (!ins) begin
                            n_miss++;
                        end else if (alloc == NB) begin
                            e_err = 1'b1; n_rej++;
                        end else begin
                            e_idx = 5'(alloc); e_wraddr = 5'(alloc);
                            tbl[alloc] = key; alloc++;
                            wr_cyc = cyc + 3; rsp_cyc = cyc + 4; n_miss++;
                        end
                    end
                    free_cyc = rsp_cyc + 1;
                end
            end else if (flush) begin
                fpend = 1'b1;
            end
            chk("req0_ready", 32'(req0_ready), 32'(e_r0));
            chk("req1_ready", 32'(req1_ready), 32'(e_r1));
        end
    end

    // Drive one request and wait for its handshake; valid drops the next cycle.
    task automatic accept(input logic id, input logic ins, input logic [7:0] key);
        bit ok;
        @(posedge clk); #1;
        if (id) begin req1_valid = 1'b1; req1_insert = ins; req1_data = key; end
        else begin req0_valid = 1'b1; req0_insert = ins; req0_data = key; end
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no ready expected ready for key %0h", key);
        end
    endtask

    // Request plus response: latency counted in cycles after the accept cycle.
    task automatic send(input logic id, input logic ins, input logic [7:0] key,
                        output int lat, output logic hit, output logic err, output logic [4:0] idx);
        accept(id, ins, key);
        lat = 0; hit = 1'bx; err = 1'bx; idx = 5'bx;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin hit = rsp_hit; err = rsp_err; idx = rsp_idx; break; end
        end
    endtask

    task automatic pulse_flush();
        @(posedge clk); #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    initial begin : watchdog
        #2ms;
        errors++;
        $display("FAIL watchdog: got no end expected $finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : stim
        int lat, n, prev, id;
        logic hit, err;
        logic [4:0] idx;
        rst = 1'b1; flush = 1'b0;
        req0_valid = 1'b0; req0_insert = 1'b0; req0_data = 8'h00;
        req1_valid = 1'b0; req1_insert = 1'b0; req1_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // First insert lands in slot 1; the lookup then hits it.
        send(1'b0, 1'b1, 8'hA5, lat, hit, err, idx);
        chk("ins_lat", 32'(lat), 32'(4));
        chk("ins_hit", 32'(hit), 32'(0));
        chk("ins_idx", 32'(idx), 32'(1));
        send(1'b1, 1'b0, 8'hA5, lat, hit, err, idx);
        chk("look_lat", 32'(lat), 32'(3));
        chk("look_hit", 32'(hit), 32'(1));
        chk("look_idx", 32'(idx), 32'(1));

        // Reserved key is rejected right away without touching the CAM.
        send(1'b0, 1'b1, 8'h00, lat, hit, err, idx);
        chk("rsv_lat", 32'(lat), 32'(1));
        chk("rsv_err", 32'(err), 32'(1));
        chk("rsv_idx", 32'(idx), 32'(0));

        // Both requesters held valid: grants must alternate.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_insert = 1'b0; req0_data = 8'h31;
        req1_valid = 1'b1; req1_insert = 1'b0; req1_data = 8'h32;
        n = 0; prev = -1;
        for (int k = 0; k < 80 && n < 6; k++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                chk("two_ready", 32'(req0_ready & req1_ready), 32'(0));
                id = req1_ready ? 1 : 0;
                if (prev >= 0) chk("alternate", 32'(id), 32'(1 - prev));
                prev = id; n++;
            end
        end
        chk("alt_count", 32'(n), 32'(6));
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Fill the table: slots 1..15, then full and a rejected insert.
        pulse_flush();
        for (int i = 1; i <= 15; i++) begin
            send(1'(i), 1'b1, 8'(8'h40 + i), lat, hit, err, idx);
            chk("fill_idx", 32'(idx), 32'(i));
        end
        chk("fill_full", 32'(full), 32'(1));
        send(1'b0, 1'b1, 8'h7E, lat, hit, err, idx);
        chk("over_err", 32'(err), 32'(1));
        chk("over_idx", 32'(idx), 32'(0));
        chk("over_lat", 32'(lat), 32'(3));
        send(1'b1, 1'b1, 8'h43, lat, hit, err, idx);
        chk("full_hit_idx", 32'(idx), 32'(3));

        // Flush during WRITE: the insert still answers, then the table clears.
        pulse_flush();
        accept(1'b0, 1'b1, 8'h11);
        @(posedge clk); #1;
        @(posedge clk); #1; flush = 1'b1;
        @(negedge clk);
        chk("fw_cam_write", 32'(cam_write), 32'(1));
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        chk("fw_rsp_valid", 32'(rsp_valid), 32'(1));
        chk("fw_rsp_idx", 32'(rsp_idx), 32'(1));
        @(negedge clk);
        @(negedge clk);
        chk("fw_rstn_low", 32'(cam_rst_n), 32'(0));
        @(negedge clk);
        @(negedge clk);
        chk("fw_full", 32'(full), 32'(0));
        send(1'b0, 1'b1, 8'h22, lat, hit, err, idx);
        chk("fw_next_idx", 32'(idx), 32'(1));

        // Randomized traffic with occasional flushes and one mid-run reset.
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            req0_valid  = ($urandom_range(0, 3) != 0);
            req0_insert = 1'($urandom_range(0, 1));
            req0_data   = 8'($urandom_range(0, 24));
            req1_valid  = ($urandom_range(0, 3) != 0);
            req1_insert = 1'($urandom_range(0, 1));
            req1_data   = 8'($urandom_range(0, 24));
            flush       = ($urandom_range(0, 199) == 0);
            rst         = (k == 1500 || k == 1501);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0; rst = 1'b0;
        repeat (10) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_ctrl.md
# cam_ctrl

Sequencing and arbitration controller for the 16-entry, 8-bit-key CAM.
- Shares the CAM between two requesters with round-robin grant.
- Turns each request into a lookup, or a lookup followed by a write into the next free slot (insert).
- Returns the matching or allocated index on a single response bus.
- Owns the CAM reset line for table flushes.

## Interface
Parameters:
- NB_ENTRIES, 16, CAM depth; slot 0 is never allocated because CAM index 0 means "no match".

Ports:
- clk  in  1  clock, shared with the CAM.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  request present.
- req0_insert / req1_insert  in  1  1 = insert-if-absent, 0 = lookup only.
- req0_data / req1_data  in  8  key.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid is also high.
- flush  in  1  one-cycle pulse; clear the table.
- rsp_valid  out  1  one-cycle response strobe; no backpressure.
- rsp_id  out  1  requester that owns the response.
- rsp_hit  out  1  key was already present.
- rsp_idx  out  5  matching or allocated slot; 0 on miss, error or full.
- rsp_err  out  1  reserved key or table full.
- full  out  1  no free slot left.
- cam_enable, cam_write  out  1  CAM lookup and write strobes.
- cam_addr  out  5  CAM write address.
- cam_data  out  8  CAM key.
- cam_rst_n  out  1  CAM asynchronous reset, active-low.
- cam_out  in  5  CAM registered match index.

## Operation
- State machine: IDLE, LOOKUP, CHECK, WRITE, RESP, FLUSH.
- IDLE:
  - A pending flush has priority and goes to FLUSH.
  - Otherwise grant round-robin. The last-granted pointer resets to 1, so requester 0 wins the first tie.
  - readyN = (state==IDLE) & grantN & ~flush_pending. A handshake latches id, insert and data, then goes to LOOKUP.
  - Reserved key: data==8'h00 goes directly to RESP with rsp_err=1, rsp_hit=0, rsp_idx=0. Unused CAM slots hold 0, so key 0 is reserved.
- LOOKUP: cam_enable=1, cam_data=key. Next state CHECK.
- CHECK: sample cam_out.
  - cam_out≠0: hit; idx=cam_out; go to RESP.
  - Miss on a lookup-only request: go to RESP with hit=0, idx=0.
  - Miss on an insert with full=1: go to RESP with err=1, idx=0.
  - Miss on an insert with full=0: go to WRITE.
- WRITE: cam_write=1, cam_addr=alloc_ptr, cam_data=key. Response idx=alloc_ptr. Then alloc_ptr+1, and full is set when the pointer reaches NB_ENTRIES. Next state RESP.
  - The CAM commits the write only while its held match result is 0. The LOOKUP→CHECK→WRITE ordering guarantees this.
- RESP: rsp_valid=1 with the latched fields. Next state IDLE.
- FLUSH: cam_rst_n=0 for exactly one cycle; alloc_ptr=1, full=0, flush_pending cleared. Next state IDLE.
- A flush arriving in any non-IDLE state sets flush_pending. The current operation completes its response first.
- alloc_ptr is 5 bits, ranges 1..NB_ENTRIES and never wraps. Once full, inserts fail until a flush.
- cam_enable, cam_write and cam_rst_n are registered decodes of state; no combinational path from req_* to the CAM.

## Timing
- Reset values:
  - state=IDLE, alloc_ptr=1, full=0, flush_pending=0.
  - All rsp_* = 0; cam_enable=0, cam_write=0, cam_addr=0, cam_data=0.
  - cam_rst_n=0 during rst, 1 in the cycle after rst deasserts.
- Handshake in cycle T:
  - cam_enable high in T+1.
  - rsp_valid in T+3 for a hit, lookup-only, or full-table request.
  - rsp_valid in T+4 for an insert miss; cam_write high in T+3.
- Reserved key: rsp_valid in T+1.
- Flush:
  - Accepted in IDLE at T: cam_rst_n low in T+1, next grant possible in T+2.
  - Both valids high in the same cycle as flush: the flush wins and no ready is asserted.
- Throughput: at most one request per 4 cycles (5 for insert-miss).
- rst mid-operation aborts the operation: no rsp_valid; the table is cleared through cam_rst_n.

## Configuration
- CAM_CTRL_STATS_EN defined:
  - Adds outputs stat_hits[15:0], stat_misses[15:0] and stat_rejects[15:0].
  - Counters saturate at 16'hFFFF and are cleared by rst or flush.
  - The counter matching each rsp_valid is incremented: hits for rsp_hit=1, rejects for rsp_err=1, misses otherwise. A successful insert counts as a miss.
- Undefined: the stat ports are still present and tied to 0, with no counter logic.

## Test plan
- After rst: insert 8'hA5 from req0 → rsp_valid 4 cycles after accept; rsp_hit=0, rsp_idx=1, cam_write high with cam_addr=1. A lookup of 8'hA5 then returns rsp_hit=1, rsp_idx=1, 3 cycles after accept.
- Both requesters hold valid with different keys → grants alternate 0,1,0,1; rsp_id follows the same order; never two readys in one cycle.
- Insert 15 distinct keys → indices 1..15 and full=1. A 16th insert gives rsp_err=1, rsp_idx=0, with no cam_write.
- Insert with key 8'h00 → rsp_err=1 one cycle after accept; cam_enable never asserted.
- Flush pulsed during WRITE → the insert still responds; cam_rst_n then goes low for one cycle; full=0; the next insert gets idx=1.
- With CAM_CTRL_STATS_EN: 3 hits, 2 misses and 1 reject → stat_hits=3, stat_misses=2, stat_rejects=1; a flush clears all three to 0.
